// File: rtl/sum_acc_pkg.sv
// Shared constants and helpers for the sum accumulator.
//   c_buf_depth  : number of entries in the result buffer
//   f_acc_width  : width needed to hold a block total without overflow
package sum_acc_pkg;

    localparam int unsigned c_buf_depth = 2;

    // An input sum is data_width+1 bits wide. Adding count of them needs
    // $clog2(count) more bits.
    function automatic int unsigned f_acc_width(input int unsigned data_width,
                                                input int unsigned count);
        return data_width + 1 + $clog2(count);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Two-entry first-word-fall-through FIFO holding completed block totals.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push         : write i_push_data (accepted if not full, or full with a pop)
//   i_pop          : remove head entry (ignored when empty)
//   o_full/o_empty : occupancy flags
//   o_level        : occupancy, 0..2
//   o_head_data    : head entry, 0 when empty
module result_fifo
    import sum_acc_pkg::*;
#(
    parameter int unsigned g_width = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [g_width-1:0] i_push_data,
    input  logic               i_pop,
    output logic               o_full,
    output logic               o_empty,
    output logic [1:0]         o_level,
    output logic [g_width-1:0] o_head_data
);

    logic [g_width-1:0] r_mem [c_buf_depth];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_level;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_level == 2'd0);
    assign o_full  = (r_level == 2'(c_buf_depth));
    assign w_pop   = i_pop && !o_empty;
    // When full, a same-edge pop frees the slot the write lands in.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_level  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_level     = r_level;
    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates blocks of g_count unsigned sums from the adder and presents each
// block total on a ready/valid output through a 2-entry result buffer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_valid, i_C : adder result stream (no backpressure, always accepted)
//   i_clear      : drop the partial block and clear the overrun flag
//   i_ready      : downstream ready
//   o_valid, o_sum : head block total
//   o_overrun    : sticky, a completed total was dropped on a full buffer
//   o_level      : result buffer occupancy
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int unsigned g_data_width = 3,
    parameter int unsigned g_count      = 4,
    parameter int unsigned g_acc_width  = f_acc_width(g_data_width, g_count)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [g_data_width:0]  i_C,
    input  logic                   i_clear,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [g_acc_width-1:0] o_sum,
    output logic                   o_overrun,
    output logic [1:0]             o_level
);

    localparam int unsigned c_cnt_width = $clog2(g_count);
    localparam logic [c_cnt_width-1:0] c_last = c_cnt_width'(g_count - 1);

    logic [g_acc_width-1:0] r_acc;
    logic [c_cnt_width-1:0] r_count;
    logic                   r_overrun;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [g_acc_width-1:0] w_total;

    // Clear discards any same-cycle sample.
    assign w_accept = i_valid && !i_clear;
    assign w_last   = (r_count == c_last);
    assign w_total  = r_acc + g_acc_width'(i_C);
    assign w_push   = w_accept && w_last;
    assign w_pop    = !w_empty && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_count <= '0;
                end else begin
                    r_acc   <= w_total;
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    result_fifo #(
        .g_width (g_acc_width)
    ) u_result_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_total),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (o_level),
        .o_head_data (o_sum)
    );

    assign o_valid   = !w_empty;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [3:0] c_in;
    logic       clear;
    logic       ready;
    logic       o_valid;
    logic [5:0] o_sum;
    logic       o_overrun;
    logic [1:0] o_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sum_accumulator dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_C       (c_in),
        .i_clear   (clear),
        .i_ready   (ready),
        .o_valid   (o_valid),
        .o_sum     (o_sum),
        .o_overrun (o_overrun),
        .o_level   (o_level)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] c);
        valid = 1'b1;
        c_in  = c;
        tick();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; c_in = 4'd9; clear = 1'b0; ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; valid = 1'b0;
        n_checks++;
        if ({o_valid, o_sum, o_overrun, o_level} !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%0b sum=%0d ovr=%0b lvl=%0d, want all 0",
                     o_valid, o_sum, o_overrun, o_level);
        end
    endtask

    task automatic test_basic();
        ready = 1'b1;
        sample(4'd14); sample(4'd14); sample(4'd14);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_early: got valid=%0b, want 0", o_valid);
        end
        sample(4'd14);
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd56 || o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_total: got valid=%0b sum=%0d ovr=%0b, want 1 56 0",
                     o_valid, o_sum, o_overrun);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_sum !== 6'd0) begin
            n_errors++;
            $display("FAIL basic_drain: got valid=%0b sum=%0d, want 0 0", o_valid, o_sum);
        end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample(4'd1);
            if (i == 3) begin
                n_checks++;
                if (o_level !== 2'd1 || o_sum !== 6'd4) begin
                    n_errors++;
                    $display("FAIL ovr_level1: got lvl=%0d sum=%0d, want 1 4", o_level, o_sum);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (o_level !== 2'd2 || o_overrun !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ovr_level2: got lvl=%0d ovr=%0b, want 2 0",
                             o_level, o_overrun);
                end
            end
        end
        n_checks++;
        if (o_level !== 2'd2 || o_overrun !== 1'b1 || o_sum !== 6'd4) begin
            n_errors++;
            $display("FAIL ovr_drop: got lvl=%0d ovr=%0b sum=%0d, want 2 1 4",
                     o_level, o_overrun, o_sum);
        end
        // Hold: head stays stable while not ready.
        tick();
        n_checks++;
        if (o_sum !== 6'd4 || o_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_hold: got valid=%0b sum=%0d, want 1 4", o_valid, o_sum);
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd4 || o_level !== 2'd1) begin
            n_errors++;
            $display("FAIL ovr_pop1: got valid=%0b sum=%0d lvl=%0d, want 1 4 1",
                     o_valid, o_sum, o_level);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_level !== 2'd0 || o_overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_pop2: got valid=%0b lvl=%0d ovr=%0b, want 0 0 1",
                     o_valid, o_level, o_overrun);
        end
    endtask

    task automatic test_full_with_pop();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if (o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL fwp_clear_ovr: got ovr=%0b, want 0", o_overrun);
        end
        ready = 1'b0;
        for (int i = 0; i < 4; i++) sample(4'd1);
        for (int i = 0; i < 4; i++) sample(4'd2);
        for (int i = 0; i < 3; i++) sample(4'd3);
        n_checks++;
        if (o_level !== 2'd2 || o_sum !== 6'd4) begin
            n_errors++;
            $display("FAIL fwp_full: got lvl=%0d sum=%0d, want 2 4", o_level, o_sum);
        end
        ready = 1'b1;
        sample(4'd3);
        n_checks++;
        if (o_level !== 2'd2 || o_overrun !== 1'b0 || o_sum !== 6'd8) begin
            n_errors++;
            $display("FAIL fwp_swap: got lvl=%0d ovr=%0b sum=%0d, want 2 0 8",
                     o_level, o_overrun, o_sum);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd12 || o_level !== 2'd1) begin
            n_errors++;
            $display("FAIL fwp_third: got valid=%0b sum=%0d lvl=%0d, want 1 12 1",
                     o_valid, o_sum, o_level);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fwp_empty: got valid=%0b, want 0", o_valid);
        end
    endtask

    task automatic test_clear();
        ready = 1'b1;
        sample(4'd3); sample(4'd3);
        clear = 1'b1;
        sample(4'd5);
        clear = 1'b0;
        sample(4'd1); sample(4'd1); sample(4'd1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_early: got valid=%0b sum=%0d, want valid 0", o_valid, o_sum);
        end
        sample(4'd1);
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd4) begin
            n_errors++;
            $display("FAIL clear_total: got valid=%0b sum=%0d, want 1 4", o_valid, o_sum);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        ready = 1'b0;
        sample(4'd1); sample(4'd2); sample(4'd3); sample(4'd4);
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd10) begin
            n_errors++;
            $display("FAIL rst_buffered: got valid=%0b sum=%0d, want 1 10", o_valid, o_sum);
        end
        sample(4'd5); sample(4'd5); sample(4'd5);
        rst = 1'b1; clear = 1'b1; ready = 1'b1;
        tick();
        rst = 1'b0; clear = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_level !== 2'd0 || o_sum !== 6'd0) begin
            n_errors++;
            $display("FAIL rst_mid: got valid=%0b lvl=%0d sum=%0d, want 0 0 0",
                     o_valid, o_level, o_sum);
        end
        sample(4'd2); sample(4'd2); sample(4'd2);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_count: got valid=%0b sum=%0d, want valid 0", o_valid, o_sum);
        end
        sample(4'd2);
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd8) begin
            n_errors++;
            $display("FAIL rst_total: got valid=%0b sum=%0d, want 1 8", o_valid, o_sum);
        end
        tick();
    endtask

    task automatic test_gapped();
        int gaps[4] = '{0, 1, 2, 3};
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // Idle cycles carry a non-zero i_C that must be ignored.
            c_in = 4'd7;
            for (int g = 0; g < gaps[i]; g++) begin
                tick();
                n_checks++;
                if (o_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gap_idle%0d_%0d: got valid=%0b, want 0", i, g, o_valid);
                end
            end
            sample(4'd7);
            if (i < 3) begin
                n_checks++;
                if (o_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gap_early%0d: got valid=%0b, want 0", i, o_valid);
                end
            end
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_sum !== 6'd28) begin
            n_errors++;
            $display("FAIL gap_total: got valid=%0b sum=%0d, want 1 28", o_valid, o_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_with_pop();
        test_clear();
        test_mid_reset();
        test_gapped();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
